axi_wr_dispatch: RTL and testbench

Write-beat dispatcher directly downstream of the AXI write interface. It takes each captured write beat (address, data, bit mask, region) and routes it to one of three targets: an internal input FIFO, the IRAM write port, or the WRAM write port. It returns exactly one completion pulse per beat, which releases WREADY and drives the BRESP selection upstream.

---
 rtl/axi_wr_dispatch.sv | 131 +++++++++++++
 tb/tb_axi_wr_dispatch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_dispatch.sv
// Write-beat dispatcher: routes captured AXI write beats to an input FIFO, IRAM or WRAM and returns one done pulse per beat.
// Optional IRAM/WRAM address range check is enabled by defining WR_DISPATCH_ADDR_CHK_EN.
module axi_wr_dispatch #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int IRAM_WORDS = 512,
  parameter int WRAM_WORDS = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          axi_wr_vld,
  input  logic [ADDR_WIDTH-1:0]         axi_wr_addr,
  input  logic [DATA_WIDTH-1:0]         axi_wr_data,
  input  logic [DATA_WIDTH-1:0]         axi_wr_strb,
  input  logic [1:0]                    axi_wr_region,
  output logic                          fifo_wr_done,
  output logic                          fifo_err,
  output logic                          iram_wr_done,
  output logic                          wram_wr_done,
  output logic                          iram_req,
  output logic                          wram_req,
  input  logic                          iram_gnt,
  input  logic                          wram_gnt,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  output logic [DATA_WIDTH-1:0]         ram_wmask,
  input  logic                          fifo_rd_en,
  output logic [DATA_WIDTH-1:0]         fifo_rd_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          dispatch_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0] IRAM_LIM = IRAM_WORDS;
  localparam logic [31:0] WRAM_LIM = WRAM_WORDS;
`ifdef WR_DISPATCH_ADDR_CHK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FIFO_PUSH, S_RAM_REQ, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_strb;
  logic [1:0]            r_region;
  logic                  r_err, r_ovf;
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic w_addr_err, w_beat_err, w_gnt, w_full, w_empty, w_pop, w_push, w_fifo_beat;

  assign w_addr_err = ADDR_CHK &&
                      (((axi_wr_region == 2'd1) && (32'(axi_wr_addr) >= IRAM_LIM)) ||
                       ((axi_wr_region == 2'd2) && (32'(axi_wr_addr) >= WRAM_LIM)));
  assign w_beat_err  = (axi_wr_region == 2'd3) || w_addr_err;
  assign w_gnt       = (r_region == 2'd1) ? iram_gnt : wram_gnt;
  assign w_full      = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
  assign w_empty     = (r_wptr == r_rptr);
  assign w_pop       = fifo_rd_en && !w_empty;
  assign w_fifo_beat = (r_region == 2'd0) && !r_err;
  assign w_push      = (r_state == S_FIFO_PUSH) && w_fifo_beat && (!w_full || w_pop);

  // Error beats pass through FIFO_PUSH (with the push suppressed) so every
  // non-RAM completion lands two cycles after the beat.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (axi_wr_vld)
                     w_next = ((axi_wr_region == 2'd0) || w_beat_err) ? S_FIFO_PUSH : S_RAM_REQ;
      S_FIFO_PUSH: w_next = S_RESP;
      S_RAM_REQ:   if (w_gnt) w_next = S_RESP;
      S_RESP:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_strb   <= '0;
      r_region <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_state <= w_next;
      if (axi_wr_vld) begin
        if (r_state == S_IDLE) begin
          r_addr   <= axi_wr_addr;
          r_data   <= axi_wr_data;
          r_strb   <= axi_wr_strb;
          r_region <= axi_wr_region;
          r_err    <= w_beat_err;
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if ((r_state == S_FIFO_PUSH) && w_fifo_beat && w_full && !w_pop)
        r_err <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Entries are stored with masked-off bits already zeroed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_data & r_strb;
  end

  assign fifo_wr_done = (r_state == S_RESP) && (r_err || (r_region == 2'd0));
  assign fifo_err     = (r_state == S_RESP) && r_err;
  assign iram_wr_done = (r_state == S_RESP) && !r_err && (r_region == 2'd1);
  assign wram_wr_done = (r_state == S_RESP) && !r_err && (r_region == 2'd2);
  assign iram_req     = (r_state == S_RAM_REQ) && (r_region == 2'd1);
  assign wram_req     = (r_state == S_RAM_REQ) && (r_region == 2'd2);
  assign ram_addr     = r_addr;
  assign ram_wdata    = r_data;
  assign ram_wmask    = r_strb;
  assign fifo_rd_data = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign fifo_empty   = w_empty;
  assign fifo_count   = r_wptr - r_rptr;
  assign dispatch_ovf = r_ovf;

endmodule

// File: tb/tb_axi_wr_dispatch.sv
// Testbench for axi_wr_dispatch: vector table plus hand-written corner sequences,
// with a done-pulse scoreboard fed at stimulus time.
module tb_axi_wr_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_wr_vld;
  logic [10:0] axi_wr_addr;
  logic [31:0] axi_wr_data, axi_wr_strb;
  logic [1:0]  axi_wr_region;
  logic        fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done;
  logic        iram_req, wram_req, iram_gnt, wram_gnt;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata, ram_wmask;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic [4:0]  fifo_count;
  logic        dispatch_ovf;

  int checks = 0;
  int failures = 0;

  // Scoreboard entry: {done kind (0 fifo, 1 iram, 2 wram), error}
  logic [2:0] sb[$];

  typedef struct {
    logic [1:0]  region;
    logic [10:0] addr;
    logic [31:0] data;
    logic [31:0] strb;
    logic [1:0]  kind;
    logic        err;
    logic [31:0] rd;
    logic [4:0]  cnt;
  } vec_t;
  vec_t vecs[6];

  axi_wr_dispatch dut (
    .clk(clk), .rst(rst),
    .axi_wr_vld(axi_wr_vld), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
    .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
    .fifo_wr_done(fifo_wr_done), .fifo_err(fifo_err),
    .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done),
    .iram_req(iram_req), .wram_req(wram_req), .iram_gnt(iram_gnt), .wram_gnt(wram_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .dispatch_ovf(dispatch_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] r, input logic [10:0] a,
                      input logic [31:0] d, input logic [31:0] s);
    axi_wr_vld = 1'b1; axi_wr_region = r; axi_wr_addr = a;
    axi_wr_data = d; axi_wr_strb = s;
    tick();
    axi_wr_vld = 1'b0;
  endtask

  // Done-pulse monitor: each pulse pops one expected completion.
  logic [1:0] mon_kind;
  int         mon_n;
  logic [2:0] mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      mon_n = int'(fifo_wr_done) + int'(iram_wr_done) + int'(wram_wr_done);
      chk("err_without_done", {31'd0, fifo_err && !fifo_wr_done}, 32'd0);
      if (mon_n > 1) chk("multiple_done", mon_n, 1);
      if (mon_n == 1) begin
        mon_kind = iram_wr_done ? 2'd1 : (wram_wr_done ? 2'd2 : 2'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", {29'd0, mon_kind, fifo_err}, 32'h7);
        end else begin
          mon_exp = sb.pop_front();
          chk("sb_done", {29'd0, mon_kind, fifo_err}, {29'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 11'h000, 32'hDEADBEEF, 32'hFFFF0000, 2'd0, 1'b0, 32'hDEAD0000, 5'd1};
    vecs[1] = '{2'd1, 11'h010, 32'hCAFEF00D, 32'h0000FFFF, 2'd1, 1'b0, 32'hDEAD0000, 5'd1};
    vecs[2] = '{2'd2, 11'h1FF, 32'h01234567, 32'hFFFFFFFF, 2'd2, 1'b0, 32'hDEAD0000, 5'd1};
    vecs[3] = '{2'd3, 11'h005, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 1'b1, 32'hDEAD0000, 5'd1};
    vecs[4] = '{2'd0, 11'h000, 32'h12345678, 32'h0000FFFF, 2'd0, 1'b0, 32'hDEAD0000, 5'd2};
`ifdef WR_DISPATCH_ADDR_CHK_EN
    vecs[5] = '{2'd2, 11'h600, 32'hA5A5A5A5, 32'hFFFFFFFF, 2'd0, 1'b1, 32'hDEAD0000, 5'd2};
`else
    vecs[5] = '{2'd2, 11'h600, 32'hA5A5A5A5, 32'hFFFFFFFF, 2'd2, 1'b0, 32'hDEAD0000, 5'd2};
`endif

    rst = 1'b1; axi_wr_vld = 1'b0; axi_wr_addr = '0; axi_wr_data = '0;
    axi_wr_strb = '0; axi_wr_region = '0; iram_gnt = 1'b1; wram_gnt = 1'b1; fifo_rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_done", {28'd0, fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done}, 32'd0);
    chk("rst_req", {30'd0, iram_req, wram_req}, 32'd0);
    chk("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_ram_wmask", ram_wmask, 32'd0);
    chk("rst_fifo", {fifo_rd_data[25:0], fifo_empty, fifo_count}, {26'd0, 1'b1, 5'd0});
    chk("rst_ovf", {31'd0, dispatch_ovf}, 32'd0);

    // Table: one beat per entry, grants already high
    for (int i = 0; i < 6; i++) begin
      sb.push_back({vecs[i].kind, vecs[i].err});
      send(vecs[i].region, vecs[i].addr, vecs[i].data, vecs[i].strb);
      chk($sformatf("v%0d_iram_req", i), {31'd0, iram_req},
          {31'd0, vecs[i].region == 2'd1 && !vecs[i].err});
      chk($sformatf("v%0d_wram_req", i), {31'd0, wram_req},
          {31'd0, vecs[i].region == 2'd2 && !vecs[i].err});
      if (vecs[i].kind != 2'd0) begin
        chk($sformatf("v%0d_ram_addr", i), {21'd0, ram_addr}, {21'd0, vecs[i].addr});
        chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].data);
        chk($sformatf("v%0d_ram_wmask", i), ram_wmask, vecs[i].strb);
      end
      tick();
      chk($sformatf("v%0d_fifo_done", i), {31'd0, fifo_wr_done}, {31'd0, vecs[i].kind == 2'd0});
      chk($sformatf("v%0d_iram_done", i), {31'd0, iram_wr_done}, {31'd0, vecs[i].kind == 2'd1});
      chk($sformatf("v%0d_wram_done", i), {31'd0, wram_wr_done}, {31'd0, vecs[i].kind == 2'd2});
      chk($sformatf("v%0d_fifo_err", i), {31'd0, fifo_err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_count", i), {27'd0, fifo_count}, {27'd0, vecs[i].cnt});
      chk($sformatf("v%0d_rd_data", i), fifo_rd_data, vecs[i].rd);
      tick();
    end

    // Drain in order, then pop while empty
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    chk("pop1_data", fifo_rd_data, 32'h00005678);
    chk("pop1_count", {27'd0, fifo_count}, 32'd1);
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    chk("pop2_empty", {31'd0, fifo_empty}, 32'd1);
    chk("pop2_data", fifo_rd_data, 32'd0);
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    chk("underflow_count", {27'd0, fifo_count}, 32'd0);

    // Fill to 16, then overflow attempt without and with a pop
    for (int i = 0; i < 16; i++) begin
      sb.push_back(3'b000);
      send(2'd0, 11'h000, 32'(i + 1), 32'hFFFFFFFF);
      tick(); tick();
    end
    chk("full_count", {27'd0, fifo_count}, 32'd16);
    sb.push_back(3'b001);
    send(2'd0, 11'h000, 32'h00000099, 32'hFFFFFFFF);
    tick();
    chk("full_err_done", {30'd0, fifo_wr_done, fifo_err}, 32'b11);
    chk("full_err_count", {27'd0, fifo_count}, 32'd16);
    tick();
    sb.push_back(3'b000);
    send(2'd0, 11'h000, 32'h00000099, 32'hFFFFFFFF);
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    chk("full_pop_done", {30'd0, fifo_wr_done, fifo_err}, 32'b10);
    chk("full_pop_count", {27'd0, fifo_count}, 32'd16);
    chk("full_pop_head", fifo_rd_data, 32'd2);
    tick();

    // IRAM grant withheld for 5 cycles
    iram_gnt = 1'b0; wram_gnt = 1'b0;
    sb.push_back(3'b010);
    send(2'd1, 11'h010, 32'h55AA55AA, 32'hFFFFFFFF);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("hold_req_c%0d", i), {31'd0, iram_req}, 32'd1);
      chk($sformatf("hold_addr_c%0d", i), {21'd0, ram_addr}, 32'h010);
      chk($sformatf("hold_done_c%0d", i), {31'd0, iram_wr_done}, 32'd0);
      if (i == 5) iram_gnt = 1'b1;
      tick();
    end
    iram_gnt = 1'b0;
    chk("hold_req_drop", {31'd0, iram_req}, 32'd0);
    chk("hold_done", {31'd0, iram_wr_done}, 32'd1);
    tick();
    chk("hold_done_once", {31'd0, iram_wr_done}, 32'd0);

    // Second beat while busy is dropped
    sb.push_back(3'b010);
    send(2'd1, 11'h020, 32'h11111111, 32'hFFFFFFFF);
    send(2'd0, 11'h000, 32'h22222222, 32'hFFFFFFFF);
    chk("ovf_set", {31'd0, dispatch_ovf}, 32'd1);
    iram_gnt = 1'b1; tick(); iram_gnt = 1'b0;
    chk("ovf_one_done", {31'd0, iram_wr_done}, 32'd1);
    tick(); tick(); tick();
    chk("ovf_sticky", {31'd0, dispatch_ovf}, 32'd1);
    chk("ovf_count", {27'd0, fifo_count}, 32'd16);

    // Reset during RAM_REQ abandons the beat and flushes the FIFO
    send(2'd2, 11'h030, 32'h33333333, 32'hFFFFFFFF);
    tick();
    chk("rstreq_req", {31'd0, wram_req}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstreq_req_drop", {31'd0, wram_req}, 32'd0);
    chk("rstreq_fifo", {fifo_rd_data[25:0], fifo_empty, fifo_count}, {26'd0, 1'b1, 5'd0});
    chk("rstreq_ovf", {31'd0, dispatch_ovf}, 32'd0);
    tick(); tick(); tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
